// File: rtl/mem_dump_ctrl.sv
// ---------------------------------------------------------------------------
// mem_dump_ctrl
//
// Halt-detect and memory-dump controller. While the core runs it counts
// cycles. When the core halts, or an optional watchdog expires, it takes over
// the RAM test port and reads every word in turn. Each word is sent out as a
// data record on a valid/ready stream (16-bit index, data, checksum in the
// Intel-HEX style). An end-of-file record closes the stream.
//
// Ports
//   CLK           clock
//   nRST          synchronous active-low reset
//   run_i         core released from reset; enables cycle counting
//   halt_i        core flushed/halted; starts the dump
//   tbctrl_o      controller owns the RAM test port
//   addr_o        RAM byte address (word index * bytes per word)
//   ren_o         RAM read enable
//   load_i        RAM read data
//   rec_valid_o   record valid
//   rec_ready_i   consumer accepts record
//   rec_idx_o     record address field (word index [15:0])
//   rec_data_o    record data word
//   rec_chksum_o  record checksum
//   rec_last_o    end-of-file record
//   cycles_o      run-cycle count (saturating)
//   timeout_o     sticky, watchdog started the dump
//   done_o        dump complete
// ---------------------------------------------------------------------------
module mem_dump_ctrl #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 16384,
    parameter int ADDR_W    = 32,
    parameter int RD_LAT    = 4,
    parameter int SKIP_ZERO = 1,
    parameter int CYC_W     = 32,
    parameter int TIMEOUT   = 0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              run_i,
    input  logic              halt_i,
    output logic              tbctrl_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              ren_o,
    input  logic [DATA_W-1:0] load_i,
    output logic              rec_valid_o,
    input  logic              rec_ready_i,
    output logic [15:0]       rec_idx_o,
    output logic [DATA_W-1:0] rec_data_o,
    output logic [7:0]        rec_chksum_o,
    output logic              rec_last_o,
    output logic [CYC_W-1:0]  cycles_o,
    output logic              timeout_o,
    output logic              done_o
);

    localparam int          NBYTES   = DATA_W / 8;
    localparam int          LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EMIT,
        S_EOF,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         idx_q, idx_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          chk_q, chk_d;
    logic [CYC_W-1:0]    cycles_q, cycles_d;
    logic                timeout_q, timeout_d;

    logic [7:0]          rd_sum;
    logic [7:0]          rd_chk;
    logic                rd_last_cycle;
    logic                timeout_hit;

    // Checksum of the record that the word now on load_i would produce.
    // The 8-bit sum wraps naturally, so the final negation is the two's
    // complement that makes the record sum to zero.
    always_comb begin
        // NOTE: blocking assignments are correct here; rd_sum is a
        // combinational accumulator that is read back within the same loop.
        rd_sum = 8'(NBYTES) + idx_q[15:8] + idx_q[7:0];
        for (int b = 0; b < NBYTES; b++) begin
            rd_sum = rd_sum + load_i[b*8 +: 8];
        end
        rd_chk = 8'd0 - rd_sum;
    end

    assign rd_last_cycle = (lat_q == LAT_W'(RD_LAT - 1));
    assign timeout_hit   = (TIMEOUT != 0) && (cycles_q == CYC_W'(TIMEOUT));

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves one unassigned (which would infer a latch).
        state_d   = state_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        data_d    = data_q;
        chk_d     = chk_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                // Halt wins over the watchdog; the exit cycle is not counted.
                if (halt_i) begin
                    state_d = S_READ;
                    idx_d   = 16'd0;
                    lat_d   = '0;
                end else if (timeout_hit) begin
                    state_d   = S_READ;
                    idx_d     = 16'd0;
                    lat_d     = '0;
                    timeout_d = 1'b1;
                end else if (run_i && (cycles_q != '1)) begin
                    cycles_d = cycles_q + CYC_W'(1);
                end
            end

            S_READ: begin
                if (rd_last_cycle) begin
                    data_d = load_i;
                    chk_d  = rd_chk;
                    lat_d  = '0;
                    if ((SKIP_ZERO != 0) && (load_i == '0)) begin
                        // Zero word: no record, go straight to the next read.
                        if (idx_q == LAST_IDX) begin
                            state_d = S_EOF;
                        end else begin
                            idx_d = idx_q + 16'd1;
                        end
                    end else begin
                        state_d = S_EMIT;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            S_EMIT: begin
                if (rec_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_EOF;
                    end else begin
                        state_d = S_READ;
                        idx_d   = idx_q + 16'd1;
                    end
                end
            end

            S_EOF: begin
                if (rec_ready_i) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments for all state so every flop samples
        // the pre-edge values regardless of statement order.
        if (!nRST) begin
            state_q   <= S_IDLE;
            idx_q     <= 16'd0;
            lat_q     <= '0;
            data_q    <= '0;
            chk_q     <= 8'd0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
            data_q    <= data_d;
            chk_q     <= chk_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs are decoded from registered state only, so the record fields
    // stay stable for as long as the consumer stalls.
    always_comb begin
        tbctrl_o     = 1'b0;
        addr_o       = '0;
        ren_o        = 1'b0;
        rec_valid_o  = 1'b0;
        rec_idx_o    = 16'd0;
        rec_data_o   = '0;
        rec_chksum_o = 8'd0;
        rec_last_o   = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            S_READ: begin
                tbctrl_o = 1'b1;
                ren_o    = 1'b1;
                addr_o   = ADDR_W'(idx_q) * ADDR_W'(NBYTES);
            end
            S_EMIT: begin
                tbctrl_o     = 1'b1;
                addr_o       = ADDR_W'(idx_q) * ADDR_W'(NBYTES);
                rec_valid_o  = 1'b1;
                rec_idx_o    = idx_q;
                rec_data_o   = data_q;
                rec_chksum_o = chk_q;
            end
            S_EOF: begin
                tbctrl_o     = 1'b1;
                addr_o       = ADDR_W'(idx_q) * ADDR_W'(NBYTES);
                rec_valid_o  = 1'b1;
                rec_last_o   = 1'b1;
                rec_chksum_o = 8'hFF;
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cycles_o  = cycles_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for mem_dump_ctrl. Two instances share the clock:
//   dut_a: NUM_WORDS=4, SKIP_ZERO=1, no watchdog   (dump flow, stall, reset)
//   dut_b: NUM_WORDS=4, SKIP_ZERO=0, TIMEOUT=50    (watchdog, mid-dump reset)
// Expected records are queued when memory contents are set up and are popped
// by a monitor whenever a record handshake happens.
// ---------------------------------------------------------------------------
module tb_mem_dump_ctrl;

    typedef struct packed {
        logic [15:0] idx;
        logic [31:0] data;
        logic [7:0]  chk;
        logic        last;
    } rec_t;

    typedef struct packed {
        logic [3:0][31:0] mem;
        int               exp_recs;
        logic [7:0]       first_chk;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic        nrst_a, run_a, halt_a, ready_a;
    logic        tbctrl_a, ren_a, valid_a, last_a, timeout_a, done_a;
    logic [31:0] addr_a, load_a, data_a, cycles_a;
    logic [15:0] idx_a;
    logic [7:0]  chk_a;
    logic [31:0] mem_a [4];
    assign load_a = mem_a[addr_a[3:2]];

    mem_dump_ctrl #(
        .DATA_W(32), .NUM_WORDS(4), .ADDR_W(32), .RD_LAT(4),
        .SKIP_ZERO(1), .CYC_W(32), .TIMEOUT(0)
    ) dut_a (
        .CLK(clk), .nRST(nrst_a), .run_i(run_a), .halt_i(halt_a),
        .tbctrl_o(tbctrl_a), .addr_o(addr_a), .ren_o(ren_a), .load_i(load_a),
        .rec_valid_o(valid_a), .rec_ready_i(ready_a), .rec_idx_o(idx_a),
        .rec_data_o(data_a), .rec_chksum_o(chk_a), .rec_last_o(last_a),
        .cycles_o(cycles_a), .timeout_o(timeout_a), .done_o(done_a)
    );

    // ---------------- instance B ----------------
    logic        nrst_b, run_b, halt_b, ready_b;
    logic        tbctrl_b, ren_b, valid_b, last_b, timeout_b, done_b;
    logic [31:0] addr_b, load_b, data_b, cycles_b;
    logic [15:0] idx_b;
    logic [7:0]  chk_b;
    logic [31:0] mem_b [4];
    assign load_b = mem_b[addr_b[3:2]];

    mem_dump_ctrl #(
        .DATA_W(32), .NUM_WORDS(4), .ADDR_W(32), .RD_LAT(4),
        .SKIP_ZERO(0), .CYC_W(32), .TIMEOUT(50)
    ) dut_b (
        .CLK(clk), .nRST(nrst_b), .run_i(run_b), .halt_i(halt_b),
        .tbctrl_o(tbctrl_b), .addr_o(addr_b), .ren_o(ren_b), .load_i(load_b),
        .rec_valid_o(valid_b), .rec_ready_i(ready_b), .rec_idx_o(idx_b),
        .rec_data_o(data_b), .rec_chksum_o(chk_b), .rec_last_o(last_b),
        .cycles_o(cycles_b), .timeout_o(timeout_b), .done_o(done_b)
    );

    rec_t       q_a[$];
    rec_t       q_b[$];
    logic [7:0] seen_a[$];
    logic [7:0] seen_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference checksum written as the plain record-sum definition.
    function automatic logic [7:0] exp_chk(input int idx, input logic [31:0] d);
        int s;
        s = 4 + ((idx >> 8) & 255) + (idx & 255);
        for (int b = 0; b < 4; b++) s = s + int'(d[b*8 +: 8]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    task automatic push_dump_a();
        rec_t r;
        for (int i = 0; i < 4; i++) begin
            if (mem_a[i] != 32'd0) begin
                r = '{idx: 16'(i), data: mem_a[i], chk: exp_chk(i, mem_a[i]), last: 1'b0};
                q_a.push_back(r);
            end
        end
        q_a.push_back('{idx: 16'd0, data: 32'd0, chk: 8'hFF, last: 1'b1});
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        nrst_a = 1'b0; run_a = 1'b0; halt_a = 1'b0;
        step(); step();
        nrst_a = 1'b1;
    endtask

    task automatic wait_done_a();
        int n;
        n = 0;
        while (!done_a && n < 300) begin
            step();
            n++;
        end
        check("done_a_reached", done_a, 1);
    endtask

    // Record monitors: a transfer happens at the next edge when valid, ready
    // and reset-release all hold in the middle of the cycle.
    initial forever begin
        rec_t e;
        @(negedge clk);
        if (nrst_a && valid_a && ready_a) begin
            seen_a.push_back(chk_a);
            if (q_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL a_unexpected_rec: got idx=0x%0h last=%0b, expected no record", idx_a, last_a);
            end else begin
                e = q_a.pop_front();
                check("a_rec_idx", idx_a, e.idx);
                check("a_rec_data", data_a, e.data);
                check("a_rec_chk", chk_a, e.chk);
                check("a_rec_last", last_a, e.last);
            end
        end
        if (nrst_b && valid_b && ready_b) begin
            seen_b.push_back(chk_b);
            if (q_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL b_unexpected_rec: got idx=0x%0h last=%0b, expected no record", idx_b, last_b);
            end else begin
                e = q_b.pop_front();
                check("b_rec_idx", idx_b, e.idx);
                check("b_rec_data", data_b, e.data);
                check("b_rec_chk", chk_b, e.chk);
                check("b_rec_last", last_b, e.last);
            end
        end
    end

    vec_t vecs[4];

    initial begin
        int base;
        int n;

        // Dump scenarios: memory image, data records expected, checksum of
        // the first record on the stream (EOF when no data records).
        vecs[0] = '{mem: {32'h0, 32'h0, 32'h12345678, 32'h0},  exp_recs: 1, first_chk: 8'hE7};
        vecs[1] = '{mem: {32'h0, 32'h0, 32'h0, 32'h0},         exp_recs: 0, first_chk: 8'hFF};
        vecs[2] = '{mem: {32'h1, 32'h0, 32'h0, 32'hFFFFFFFF},  exp_recs: 2, first_chk: 8'h00};
        vecs[3] = '{mem: {32'h0, 32'h0, 32'h80, 32'h01020304}, exp_recs: 2, first_chk: 8'hF2};

        nrst_a = 1'b0; run_a = 1'b0; halt_a = 1'b0; ready_a = 1'b1;
        nrst_b = 1'b0; run_b = 1'b0; halt_b = 1'b0; ready_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 32'd0;
            mem_b[i] = 32'd0;
        end

        // ---- Reset held with halt asserted ----
        halt_a = 1'b1;
        step(); step();
        check("rst_flags", {tbctrl_a, ren_a, valid_a, last_a, timeout_a, done_a}, 6'd0);
        check("rst_cycles", cycles_a, 0);
        check("rst_addr", addr_a, 0);
        push_dump_a();
        nrst_a = 1'b1;
        step();
        check("rst_release_tbctrl", tbctrl_a, 1);
        wait_done_a();
        check("rst_dump_q_empty", q_a.size(), 0);

        // ---- Table-driven dumps ----
        for (int v = 0; v < 4; v++) begin
            reset_a();
            for (int i = 0; i < 4; i++) mem_a[i] = vecs[v].mem[i];
            push_dump_a();
            base = seen_a.size();
            run_a = 1'b1;
            repeat (100) step();
            check("count_100", cycles_a, 100);
            halt_a = 1'b1;
            step();
            check("halt_not_counted", cycles_a, 100);
            for (int k = 0; k < 4; k++) begin
                check("rd0_hold", {tbctrl_a, ren_a, addr_a}, {1'b1, 1'b1, 32'd0});
                step();
            end
            if (vecs[v].mem[0] == 32'd0)
                check("rd1_addr", {ren_a, addr_a}, {1'b1, 32'd4});
            else
                check("rd0_emit", {valid_a, ren_a}, 2'b10);
            wait_done_a();
            check("done_tbctrl", tbctrl_a, 0);
            check("done_cycles_frozen", cycles_a, 100);
            check("rec_count", seen_a.size() - base, vecs[v].exp_recs + 1);
            if (seen_a.size() > base)
                check("first_chk", seen_a[base], vecs[v].first_chk);
            check("q_a_empty", q_a.size(), 0);
        end

        // ---- Consumer stall in EMIT ----
        reset_a();
        for (int i = 0; i < 4; i++) mem_a[i] = vecs[0].mem[i];
        push_dump_a();
        base = seen_a.size();
        ready_a = 1'b0;
        halt_a = 1'b1;
        n = 0;
        while (!valid_a && n < 100) begin
            step();
            n++;
        end
        check("stall_valid_seen", valid_a, 1);
        repeat (10) begin
            step();
            check("stall_hold", {valid_a, ren_a, data_a, chk_a, addr_a},
                  {1'b1, 1'b0, 32'h12345678, 8'hE7, 32'd4});
        end
        ready_a = 1'b1;
        step();
        check("stall_accept_next", {valid_a, ren_a, addr_a}, {1'b0, 1'b1, 32'd8});
        wait_done_a();
        check("stall_rec_count", seen_a.size() - base, 2);

        // ---- Watchdog ----
        step(); step();
        nrst_b = 1'b1;
        run_b = 1'b1;
        n = 0;
        while (!tbctrl_b && n < 200) begin
            step();
            n++;
        end
        check("wd_start", tbctrl_b, 1);
        check("wd_cycles", cycles_b, 50);
        check("wd_timeout", timeout_b, 1);
        nrst_b = 1'b0; run_b = 1'b0;
        step();
        check("wd_reset", {tbctrl_b, timeout_b, cycles_b}, 34'd0);
        nrst_b = 1'b1;
        run_b = 1'b1;
        repeat (50) step();
        halt_b = 1'b1;
        step();
        check("wd_halt_tie", {tbctrl_b, timeout_b, cycles_b}, {1'b1, 1'b0, 32'd50});
        nrst_b = 1'b0; run_b = 1'b0; halt_b = 1'b0;
        step();

        // ---- Reset during the READ of index 2, no zero skipping ----
        base = seen_b.size();
        q_b.push_back('{idx: 16'd0, data: 32'd0, chk: exp_chk(0, 32'd0), last: 1'b0});
        q_b.push_back('{idx: 16'd1, data: 32'd0, chk: exp_chk(1, 32'd0), last: 1'b0});
        nrst_b = 1'b1;
        halt_b = 1'b1;
        n = 0;
        while (!(ren_b && addr_b == 32'd8) && n < 100) begin
            step();
            n++;
        end
        check("mid_read2_reached", {ren_b, addr_b}, {1'b1, 32'd8});
        nrst_b = 1'b0;
        halt_b = 1'b0;
        step();
        check("mid_reset_outs", {tbctrl_b, ren_b, valid_b, done_b, cycles_b}, 36'd0);
        nrst_b = 1'b1;
        repeat (20) step();
        check("mid_idle", {tbctrl_b, valid_b, cycles_b}, 34'd0);
        check("mid_rec_count", seen_b.size() - base, 2);
        if (seen_b.size() >= base + 2) begin
            check("mid_chk0", seen_b[base], 8'hFC);
            check("mid_chk1", seen_b[base+1], 8'hFB);
        end
        check("q_b_empty", q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
